// File: rtl/spec_reg_arbiter_pkg.sv
// spec_reg_arbiter_pkg: register index constants, requester IDs and arbiter helpers
package spec_reg_arbiter_pkg;
    localparam int ZR   = 0;
    localparam int SP   = 4;
    localparam int LR   = 5;
    localparam int PC   = 6;
    localparam int CPSR = 7;

    typedef enum logic [1:0] {
        REQ_LNK  = 2'd0,
        REQ_STK  = 2'd1,
        REQ_USR  = 2'd2,
        REQ_NONE = 2'd3
    } req_id_e;

    function automatic req_id_e oh2id(input logic [2:0] oh);
        return oh[0] ? REQ_LNK : oh[1] ? REQ_STK : oh[2] ? REQ_USR : REQ_NONE;
    endfunction

    function automatic req_id_e rr_next(input req_id_e id);
        return id == REQ_LNK ? REQ_STK : id == REQ_STK ? REQ_USR : REQ_LNK;
    endfunction
endpackage

// File: rtl/spec_reg_arbiter_rr_grant3.sv
// rr_grant3: three-way round-robin grant, ptr_i names the highest-priority request
module rr_grant3 (
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o
);
    logic [2:0] rot;
    logic [2:0] g;

    // rotate so bit 0 is the priority holder, fixed-priority pick, rotate back
    always_comb begin
        rot   = ptr_i == 2'd1 ? {req_i[0], req_i[2], req_i[1]} :
                ptr_i == 2'd2 ? {req_i[1], req_i[0], req_i[2]} : req_i;
        g     = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        gnt_o = ptr_i == 2'd1 ? {g[1], g[0], g[2]} :
                ptr_i == 2'd2 ? {g[0], g[2], g[1]} : g;
    end
endmodule

// File: rtl/spec_reg_arbiter.sv
// spec_reg_arbiter: round-robin arbitration of three writers onto one special-register write port
module spec_reg_arbiter
    import spec_reg_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              lnk_valid,
    input  logic              stk_valid,
    input  logic              usr_valid,
    output logic              lnk_ready,
    output logic              stk_ready,
    output logic              usr_ready,
    input  logic [ADDR_W-1:0] lnk_addr,
    input  logic [ADDR_W-1:0] stk_addr,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] lnk_data,
    input  logic [DATA_W-1:0] stk_data,
    input  logic [DATA_W-1:0] usr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              zr_drop,
    output logic [1:0]        last_grant
);
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic              xfer;
    req_id_e           gid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    req_id_e           ptr_q, ptr_d, last_q, last_d;
    logic              wr_en_q, wr_en_d, zr_drop_q, zr_drop_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    assign req = (rst || stall) ? 3'b000 : {usr_valid, stk_valid, lnk_valid};

    rr_grant3 u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign {usr_ready, stk_ready, lnk_ready} = gnt;
    assign xfer       = |gnt;
    assign gid        = oh2id(gnt);
    assign sel_addr   = gnt[1] ? stk_addr : gnt[2] ? usr_addr : lnk_addr;
    assign sel_data   = gnt[1] ? stk_data : gnt[2] ? usr_data : lnk_data;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign zr_drop    = zr_drop_q;
    assign last_grant = last_q;

    // next state: writes to the zero register are dropped but still rotate priority
    always_comb begin
        ptr_d     = xfer ? rr_next(gid) : ptr_q;
        wr_en_d   = xfer && sel_addr != ADDR_W'(ZR);
        zr_drop_d = xfer && sel_addr == ADDR_W'(ZR);
        wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
        wr_data_d = wr_en_d ? sel_data : wr_data_q;
        last_d    = xfer ? gid : last_q;
    end

    // state registers; reset gives link first priority and clears the write port
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= REQ_LNK;
            wr_en_q   <= 1'b0;
            zr_drop_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            last_q    <= REQ_NONE;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            zr_drop_q <= zr_drop_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
        end
    end
endmodule

// File: tb/tb_spec_reg_arbiter.sv
// tb_spec_reg_arbiter: directed checks of spec_reg_arbiter arbitration, latency, stall and reset
module tb_spec_reg_arbiter;
    logic        clk, rst, stall;
    logic        lnk_valid, stk_valid, usr_valid;
    logic        lnk_ready, stk_ready, usr_ready;
    logic [2:0]  lnk_addr, stk_addr, usr_addr;
    logic [31:0] lnk_data, stk_data, usr_data;
    logic        wr_en, zr_drop;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  last_grant;
    int          vectors = 0;
    int          miscompares = 0;

    spec_reg_arbiter dut (
        .clk(clk), .rst(rst), .stall(stall),
        .lnk_valid(lnk_valid), .stk_valid(stk_valid), .usr_valid(usr_valid),
        .lnk_ready(lnk_ready), .stk_ready(stk_ready), .usr_ready(usr_ready),
        .lnk_addr(lnk_addr), .stk_addr(stk_addr), .usr_addr(usr_addr),
        .lnk_data(lnk_data), .stk_data(stk_data), .usr_data(usr_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .zr_drop(zr_drop), .last_grant(last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lnk_valid = 0; stk_valid = 0; usr_valid = 0; stall = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        lnk_valid = 1; stk_valid = 1; usr_valid = 1;
        lnk_addr = 3'd1; stk_addr = 3'd2; usr_addr = 3'd3;
        lnk_data = 32'h11; stk_data = 32'h22; usr_data = 32'h33;
        rst = 1;
        step();
        step();
        vectors++;
        if ({lnk_ready, stk_ready, usr_ready} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ready got=%b exp=000", {lnk_ready, stk_ready, usr_ready});
        end
        vectors++;
        if ({wr_en, zr_drop, wr_addr, wr_data, last_grant} !== {1'b0, 1'b0, 3'd0, 32'd0, 2'd3}) begin
            miscompares++;
            $display("FAIL reset_outputs got wr_en=%b zr=%b addr=%0d data=%h lg=%0d exp 0 0 0 0 3",
                     wr_en, zr_drop, wr_addr, wr_data, last_grant);
        end
        rst = 0;
        idle();
    endtask

    task automatic test_single();
        usr_valid = 1; usr_addr = 3'd4; usr_data = 32'h0000_1000;
        #1;
        vectors++;
        if ({lnk_ready, stk_ready, usr_ready} !== 3'b001) begin
            miscompares++; $display("FAIL single_ready got=%b exp=001", {lnk_ready, stk_ready, usr_ready});
        end
        step();
        usr_valid = 0;
        vectors++;
        if ({wr_en, wr_addr, wr_data, last_grant} !== {1'b1, 3'd4, 32'h0000_1000, 2'd2}) begin
            miscompares++;
            $display("FAIL single_write got en=%b addr=%0d data=%h lg=%0d exp 1 4 00001000 2",
                     wr_en, wr_addr, wr_data, last_grant);
        end
        step();
        vectors++;
        if ({wr_en, wr_addr, wr_data, last_grant} !== {1'b0, 3'd4, 32'h0000_1000, 2'd2}) begin
            miscompares++;
            $display("FAIL single_hold got en=%b addr=%0d data=%h lg=%0d exp 0 4 00001000 2",
                     wr_en, wr_addr, wr_data, last_grant);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_rdy;
        logic [2:0]  exp_addr;
        logic [31:0] exp_data;
        do_reset();
        lnk_addr = 3'd1; stk_addr = 3'd2; usr_addr = 3'd3;
        lnk_data = 32'hA1; stk_data = 32'hB2; usr_data = 32'hC3;
        lnk_valid = 1; stk_valid = 1; usr_valid = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy  = (i % 3 == 0) ? 3'b100 : (i % 3 == 1) ? 3'b010 : 3'b001;
            exp_addr = 3'((i % 3) + 1);
            exp_data = (i % 3 == 0) ? 32'hA1 : (i % 3 == 1) ? 32'hB2 : 32'hC3;
            vectors++;
            if ({lnk_ready, stk_ready, usr_ready} !== exp_rdy) begin
                miscompares++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, {lnk_ready, stk_ready, usr_ready}, exp_rdy);
            end
            step();
            vectors++;
            if ({wr_en, wr_addr, wr_data, last_grant} !== {1'b1, exp_addr, exp_data, 2'(i % 3)}) begin
                miscompares++;
                $display("FAIL rr_write[%0d] got en=%b addr=%0d data=%h lg=%0d exp 1 %0d %h %0d",
                         i, wr_en, wr_addr, wr_data, last_grant, exp_addr, exp_data, i % 3);
            end
        end
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        lnk_valid = 1; lnk_addr = 3'd0; lnk_data = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (lnk_ready !== 1'b1) begin
            miscompares++; $display("FAIL zr_ready got=%b exp=1", lnk_ready);
        end
        step();
        lnk_valid = 0;
        vectors++;
        if ({wr_en, zr_drop, last_grant} !== {1'b0, 1'b1, 2'd0}) begin
            miscompares++; $display("FAIL zr_drop got en=%b zr=%b lg=%0d exp 0 1 0", wr_en, zr_drop, last_grant);
        end
        step();
        vectors++;
        if ({wr_en, zr_drop, last_grant} !== {1'b0, 1'b0, 2'd0}) begin
            miscompares++; $display("FAIL zr_pulse got en=%b zr=%b lg=%0d exp 0 0 0", wr_en, zr_drop, last_grant);
        end
    endtask

    task automatic test_stall();
        stall = 1; stk_valid = 1; stk_addr = 3'd5; stk_data = 32'h0000_ABCD;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({stk_ready, wr_en} !== 2'b00) begin
                miscompares++; $display("FAIL stall_hold[%0d] got rdy=%b en=%b exp 0 0", i, stk_ready, wr_en);
            end
            step();
        end
        stall = 0;
        #1;
        vectors++;
        if (stk_ready !== 1'b1) begin
            miscompares++; $display("FAIL stall_release got=%b exp=1", stk_ready);
        end
        step();
        stk_valid = 0;
        stall = 1;
        vectors++;
        if ({wr_en, wr_addr, wr_data, last_grant} !== {1'b1, 3'd5, 32'h0000_ABCD, 2'd1}) begin
            miscompares++;
            $display("FAIL stall_write got en=%b addr=%0d data=%h lg=%0d exp 1 5 0000abcd 1",
                     wr_en, wr_addr, wr_data, last_grant);
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        usr_valid = 1; usr_addr = 3'd6; usr_data = 32'h0000_0666;
        rst = 1;
        #1;
        vectors++;
        if (usr_ready !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_ready got=%b exp=0", usr_ready);
        end
        step();
        rst = 0;
        vectors++;
        if ({wr_en, last_grant} !== {1'b0, 2'd3}) begin
            miscompares++; $display("FAIL rstmid_out got en=%b lg=%0d exp 0 3", wr_en, last_grant);
        end
        lnk_valid = 1; stk_valid = 1; lnk_addr = 3'd7; lnk_data = 32'h7;
        #1;
        vectors++;
        if ({lnk_ready, stk_ready, usr_ready} !== 3'b100) begin
            miscompares++; $display("FAIL rstmid_first got=%b exp=100", {lnk_ready, stk_ready, usr_ready});
        end
        step();
        idle();
        vectors++;
        if ({wr_en, wr_addr, last_grant} !== {1'b1, 3'd7, 2'd0}) begin
            miscompares++; $display("FAIL rstmid_write got en=%b addr=%0d lg=%0d exp 1 7 0", wr_en, wr_addr, last_grant);
        end
    endtask

    task automatic test_starvation();
        int         ptr;
        int         gap;
        logic [2:0] v;
        logic [2:0] exp;
        do_reset();
        ptr = 0;
        gap = 0;
        usr_valid = 1; usr_addr = 3'd2; lnk_addr = 3'd1; stk_addr = 3'd3;
        for (int c = 0; c < 100; c++) begin
            lnk_valid = 1'($urandom_range(0, 1));
            stk_valid = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            #1;
            v = {usr_valid, stk_valid, lnk_valid};
            exp = 3'b000;
            if (!stall)
                for (int k = 0; k < 3; k++)
                    if (exp == 3'b000 && v[(ptr + k) % 3]) exp = 3'(1 << ((ptr + k) % 3));
            vectors++;
            if ({usr_ready, stk_ready, lnk_ready} !== exp) begin
                miscompares++;
                $display("FAIL starve_grant[%0d] got=%b exp=%b", c, {usr_ready, stk_ready, lnk_ready}, exp);
            end
            for (int k = 0; k < 3; k++)
                if (exp[k]) ptr = (k + 1) % 3;
            if (!stall) gap = usr_ready ? 0 : gap + 1;
            if (gap >= 3) begin
                miscompares++;
                $display("FAIL starve_bound[%0d] got gap=%0d exp<3", c, gap);
                gap = 0;
            end
            step();
        end
        idle();
        step();
    endtask

    initial begin
        rst = 1;
        idle();
        lnk_addr = 0; stk_addr = 0; usr_addr = 0;
        lnk_data = 0; stk_data = 0; usr_data = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_stall();
        test_reset_mid();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
